// File: rtl/alu_4bit_checker_if.sv
// Vector stream from the ALU under test into the response checker (valid/ready).
interface alu_4bit_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH:0]   result;

  modport master (output in_valid, a, b, sel, result, input in_ready);
  modport slave  (input in_valid, a, b, sel, result, output in_ready);
endinterface

// File: rtl/alu_4bit_checker.sv
// ALU response checker: counters update 2 edges after a transfer; in_ready is high only in RUN.
// ALU_CHECKER_FAIL_STOP_EN adds a HALT state entered on the first mismatch.
module alu_4bit_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  alu_4bit_checker_if.slave  vec,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               error,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic [WIDTH:0]     first_fail_exp
);
  typedef enum logic [2:0] {
`ifdef ALU_CHECKER_FAIL_STOP_EN
    HALT,
`endif
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   num_vec_q, num_vec_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic               stage_vld_q, stage_vld_d;
  logic [WIDTH:0]     stage_exp_q, stage_exp_d;
  logic [WIDTH:0]     stage_res_q, stage_res_d;
  logic [CNT_W-1:0]   stage_idx_q, stage_idx_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
  logic [WIDTH:0]     ff_exp_q, ff_exp_d;
  logic               xfer;
  logic               mismatch;

  function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] op_a,
                                             input logic [WIDTH-1:0] op_b,
                                             input logic [1:0]       op_sel);
    logic [WIDTH:0] r;
    case (op_sel)
      2'b00:   r = {1'b0, op_a & op_b};
      2'b01:   r = {1'b0, op_a | op_b};
      2'b10:   r = {1'b0, op_a} + {1'b0, op_b};
      default: r = {1'b0, op_a} - {1'b0, op_b};
    endcase
    return r;
  endfunction

  always_comb begin
    xfer        = vec.in_valid & in_ready_q;
    mismatch    = stage_vld_q & (stage_res_q != stage_exp_q);
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    acc_cnt_d   = acc_cnt_q;
    stage_vld_d = xfer;
    stage_exp_d = stage_exp_q;
    stage_res_d = stage_res_q;
    stage_idx_d = stage_idx_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    error_d     = error_q;
    ff_idx_d    = ff_idx_q;
    ff_exp_d    = ff_exp_q;

    if (xfer) begin
      stage_exp_d = alu_ref(vec.a, vec.b, vec.sel);
      stage_res_d = vec.result;
      stage_idx_d = acc_cnt_q;
    end

    if (stage_vld_q) begin
      if (mismatch) begin
        fail_cnt_d = fail_cnt_q + CNT_ONE;
        if (!error_q) begin
          error_d  = 1'b1;
          ff_idx_d = stage_idx_q;
          ff_exp_d = stage_exp_q;
        end
      end else begin
        pass_cnt_d = pass_cnt_q + CNT_ONE;
      end
    end

    case (state_q)
      RUN: begin
        if (xfer) begin
          acc_cnt_d = acc_cnt_q + CNT_ONE;
          if (acc_cnt_q == num_vec_q - CNT_ONE) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      default: begin
        // IDLE, DONE and HALT all restart the same way; a restart drops any pending compare.
        if (start) begin
          state_d     = (num_vec == '0) ? DONE : RUN;
          num_vec_d   = num_vec;
          acc_cnt_d   = '0;
          stage_vld_d = 1'b0;
          pass_cnt_d  = '0;
          fail_cnt_d  = '0;
          error_d     = 1'b0;
          ff_idx_d    = '0;
          ff_exp_d    = '0;
        end
      end
    endcase

`ifdef ALU_CHECKER_FAIL_STOP_EN
    if (mismatch && !error_q && (state_q == RUN || state_q == DRAIN)) state_d = HALT;
    busy_d = (state_d == RUN) || (state_d == DRAIN) || (state_d == HALT);
`else
    busy_d = (state_d == RUN) || (state_d == DRAIN);
`endif
    in_ready_d = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      num_vec_q   <= '0;
      acc_cnt_q   <= '0;
      stage_vld_q <= 1'b0;
      stage_exp_q <= '0;
      stage_res_q <= '0;
      stage_idx_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      error_q     <= 1'b0;
      ff_idx_q    <= '0;
      ff_exp_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      num_vec_q   <= num_vec_d;
      acc_cnt_q   <= acc_cnt_d;
      stage_vld_q <= stage_vld_d;
      stage_exp_q <= stage_exp_d;
      stage_res_q <= stage_res_d;
      stage_idx_q <= stage_idx_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      error_q     <= error_d;
      ff_idx_q    <= ff_idx_d;
      ff_exp_q    <= ff_exp_d;
    end
  end

  assign vec.in_ready    = in_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign error           = error_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_exp  = ff_exp_q;
endmodule

// File: doc/alu_4bit_checker.md
Name: alu_4bit_checker

Overview:
- Response checker for the 4-bit ALU: the consuming end of the ALU vector stream.
- Accepts (a, b, sel, result) vectors over a valid/ready handshake.
- Computes the expected ALU output with its own reference model and compares it against `result`.
- Keeps pass/fail counts, a sticky error flag and first-failure capture, so self-checking benches and on-chip BIST report a verdict instead of relying on waveform inspection.

Parameters:
- WIDTH, 4, operand width; result and expected are WIDTH+1 bits.
- CNT_W, 16, width of the vector-count input, the pass/fail counters and the failure index.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; clears counters and begins a run of num_vec vectors
- num_vec  input  CNT_W  vectors expected in the run; sampled on start
- in_valid  input  1  vector present on a/b/sel/result
- in_ready  output  1  checker can accept a vector this cycle
- a  input  WIDTH  operand A as applied to the ALU
- b  input  WIDTH  operand B as applied to the ALU
- sel  input  2  opcode: 00 AND, 01 OR, 10 ADD, 11 SUB
- result  input  WIDTH+1  ALU output under test
- busy  output  1  high in RUN/DRAIN (and HALT when enabled)
- done  output  1  high in DONE
- pass_cnt  output  CNT_W  matching vectors
- fail_cnt  output  CNT_W  mismatching vectors
- error  output  1  sticky; set on first mismatch
- first_fail_idx  output  CNT_W  0-based index of first mismatching vector
- first_fail_exp  output  WIDTH+1  expected value for first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, busy, done, error = 0; all counters, first_fail_idx and first_fail_exp = 0; pipeline valid bit cleared. Reset mid-run abandons the run with no partial report.
- Reference model, all ops in WIDTH+1 bits:
  - AND/OR: zero-extended bitwise result; bit WIDTH = 0.
  - ADD: {0,a} + {0,b}; bit WIDTH = carry.
  - SUB: ({0,a} - {0,b}) mod 2^(WIDTH+1). Example: 1-2 = 5'b11111.
- Compare is full-width equality, WIDTH+1 bits.
- Handshake:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - in_ready is a registered state decode: 1 only in RUN.
  - Inputs are ignored when no transfer occurs.
- Pipeline:
  - Edge E0 (transfer): vector and expected value captured into a stage register, tagged with the accept index.
  - Edge E1: compare; pass_cnt or fail_cnt increments. On the first mismatch, error, first_fail_idx and first_fail_exp load.
  - Counters are visible after E1, i.e. a 2-edge latency from transfer.
  - Back-to-back transfers are supported: one vector per cycle.
- State machine:
  - IDLE: start with num_vec=0 -> DONE. start with num_vec>0 -> RUN, clearing counters and error.
  - RUN: count accepted vectors. On accepting vector num_vec-1 -> DRAIN; in_ready falls the following cycle, so no extra vector is accepted.
  - DRAIN: one cycle for the final compare -> DONE.
  - DONE: outputs hold. start restarts exactly as from IDLE.
- start in RUN/DRAIN is ignored.
- Counters never wrap: num_vec bounds total transfers and pass_cnt+fail_cnt = num_vec at DONE.
- Later mismatches do not overwrite the first_fail_* registers.

Optional Feature:
- Macro: ALU_CHECKER_FAIL_STOP_EN.
- Defined:
  - On the first mismatch (edge E1), the FSM enters HALT.
  - In HALT, in_ready = 0 and busy = 1; any vector already in the capture stage is still compared and counted.
  - start leaves HALT and restarts as from IDLE.
  - done stays 0 in HALT.
- Undefined: HALT does not exist; mismatches are counted and the run always completes to DONE.

Test Plan:
- Reset then start, num_vec=8; the 8 vectors below, each with the correct result, back-to-back -> in_ready held 1 for 8 cycles; DONE with pass_cnt=8, fail_cnt=0, error=0.
  - AND: 1100&1010 -> 01000; 1111&0000 -> 00000.
  - OR: 1100|1010 -> 01110; 1111|0000 -> 01111.
  - ADD: 0011+0101 -> 01000; 1111+0001 -> 10000.
  - SUB: 1000-0011 -> 00101; 0001-0010 -> 11111.
- Same run, but vector 5 (ADD 1111+0001) carries result=00000 -> fail_cnt=1, pass_cnt=7, error=1, first_fail_idx=5, first_fail_exp=10000.
- num_vec=4 with in_valid toggling every other cycle, and a 9th vector offered after the 4th -> exactly 4 accepted; in_ready=0 from the cycle after the 4th transfer; done=1 two edges after the last transfer.
- start with num_vec=0 -> done=1 one cycle later; counters=0; in_ready never asserted.
- rst_n pulled low mid-run after 3 transfers -> all outputs 0 immediately (asynchronously); fresh start with num_vec=2 then completes normally.
- With ALU_CHECKER_FAIL_STOP_EN: num_vec=8, mismatch on vector 2 -> HALT; fail_cnt=1, pass_cnt counts vectors 0,1 plus any correct vector 3 already captured; in_ready stays 0; done=0.
